// File: rtl/pipe_ctrl.sv
// Y86-64 five-stage pipeline control: hazard stall/bubble generation plus a run-state FSM
// (post-reset flush, exception drain, halt). Define PIPE_CTRL_PERF_EN for hazard counters.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] D_icode,
  input  logic [3:0] E_icode,
  input  logic [3:0] M_icode,
  input  logic [3:0] E_dstM,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic       e_Cnd,
  input  logic [1:0] m_stat,
  input  logic [1:0] W_stat,
  output logic       F_stall,
  output logic       D_stall,
  output logic       D_bubble,
  output logic       E_bubble,
  output logic       M_bubble,
  output logic       W_stall,
  output logic       set_cc,
  output logic       halted,
  output logic [1:0] exc_stat
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] lu_cnt,
  output logic [31:0] ret_cnt,
  output logic [31:0] mp_cnt
`endif
);

  localparam logic [1:0] StatAok   = 2'd0;
  localparam logic [3:0] IMrmovq   = 4'h5;
  localparam logic [3:0] IOpq      = 4'h6;
  localparam logic [3:0] IJxx      = 4'h7;
  localparam logic [3:0] IRet      = 4'h9;
  localparam logic [3:0] IPopq     = 4'hB;
  localparam logic [3:0] RNone     = 4'hF;
  localparam logic [3:0] FlushLast = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {StFlush, StRun, StDrain, StHalted} stateT;

  stateT      stateQ, stateD;
  logic [3:0] flushCntQ, flushCntD;
  logic [1:0] excStatQ, excStatD;

  logic loadUse, retHaz, misPred, mBad, wBad;

  always_comb begin
    loadUse = ((E_icode == IMrmovq) || (E_icode == IPopq)) && (E_dstM != RNone) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    retHaz  = (D_icode == IRet) || (E_icode == IRet) || (M_icode == IRet);
    misPred = (E_icode == IJxx) && !e_Cnd;
    mBad    = (m_stat != StatAok);
    wBad    = (W_stat != StatAok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= StFlush;
      flushCntQ <= 4'd0;
      excStatQ  <= 2'd0;
    end else begin
      stateQ    <= stateD;
      flushCntQ <= flushCntD;
      excStatQ  <= excStatD;
    end
  end

  always_comb begin
    stateD    = stateQ;
    flushCntD = flushCntQ;
    unique case (stateQ)
      StFlush: begin
        flushCntD = flushCntQ + 4'd1;
        if (flushCntQ == FlushLast) stateD = StRun;
      end
      // A W-stage fault wins over a simultaneous M-stage fault: nothing left to drain.
      StRun: begin
        if (wBad)      stateD = StHalted;
        else if (mBad) stateD = StDrain;
      end
      StDrain: begin
        if (wBad) stateD = StHalted;
      end
      default: stateD = StHalted;
    endcase
    excStatD = ((stateD == StHalted) && (stateQ != StHalted)) ? W_stat : excStatQ;
  end

  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    set_cc   = 1'b0;
    halted   = 1'b0;
    unique case (stateQ)
      StFlush: begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
      end
      StRun: begin
        F_stall  = loadUse || retHaz;
        D_stall  = loadUse;
        D_bubble = misPred || (retHaz && !loadUse);
        E_bubble = misPred || loadUse;
        M_bubble = mBad || wBad;
        W_stall  = wBad;
        set_cc   = (E_icode == IOpq) && !mBad && !wBad;
      end
      StDrain: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = wBad;
      end
      default: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        W_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        halted   = 1'b1;
      end
    endcase
  end

  assign exc_stat = excStatQ;

`ifdef PIPE_CTRL_PERF_EN
  // Saturating counters, only advanced while the pipe is in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= 32'd0;
      lu_cnt  <= 32'd0;
      ret_cnt <= 32'd0;
      mp_cnt  <= 32'd0;
    end else if (stateQ == StRun) begin
      if (cyc_cnt != '1)            cyc_cnt <= cyc_cnt + 32'd1;
      if (loadUse && lu_cnt != '1)  lu_cnt  <= lu_cnt + 32'd1;
      if (retHaz && ret_cnt != '1)  ret_cnt <= ret_cnt + 32'd1;
      if (misPred && mp_cnt != '1)  mp_cnt  <= mp_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; inputs change and outputs are checked just
// after the falling edge, well away from the rising edge the pipe registers use.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB;
  logic       e_Cnd;
  logic [1:0] m_stat, W_stat;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
  logic [1:0] exc_stat;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] cyc_cnt, lu_cnt, ret_cnt, mp_cnt;
`endif

  logic [7:0] ctl;
  assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted};

  // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted}
  localparam logic [7:0] CFlush  = 8'b1011_1000;
  localparam logic [7:0] CIdle   = 8'b0000_0000;
  localparam logic [7:0] CLoad   = 8'b1101_0000;
  localparam logic [7:0] CRet    = 8'b1010_0000;

  int nTests = 0;
  int nFail  = 0;

  pipe_ctrl #(.FLUSH_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .D_icode  (D_icode),
    .E_icode  (E_icode),
    .M_icode  (M_icode),
    .E_dstM   (E_dstM),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .e_Cnd    (e_Cnd),
    .m_stat   (m_stat),
    .W_stat   (W_stat),
    .F_stall  (F_stall),
    .D_stall  (D_stall),
    .D_bubble (D_bubble),
    .E_bubble (E_bubble),
    .M_bubble (M_bubble),
    .W_stall  (W_stall),
    .set_cc   (set_cc),
    .halted   (halted),
    .exc_stat (exc_stat)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .cyc_cnt  (cyc_cnt),
    .lu_cnt   (lu_cnt),
    .ret_cnt  (ret_cnt),
    .mp_cnt   (mp_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setIn(input logic [3:0] d, input logic [3:0] e, input logic [3:0] m,
                       input logic [3:0] dst, input logic [3:0] sa, input logic [3:0] sb,
                       input logic cnd, input logic [1:0] ms, input logic [1:0] ws);
    D_icode = d; E_icode = e; M_icode = m; E_dstM = dst;
    d_srcA = sa; d_srcB = sb; e_Cnd = cnd; m_stat = ms; W_stat = ws;
  endtask

  task automatic nop();
    setIn(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0);
  endtask

  // Inputs already applied at the falling edge; check then advance one cycle.
  task automatic step(input string tag, input logic [7:0] exp);
    #1;
    check(tag, 32'(ctl), 32'(exp));
    @(negedge clk);
  endtask

  task automatic flushPhase(input string tag);
    for (int i = 0; i < 4; i++) step(tag, CFlush);
  endtask

  initial begin
    rst_n = 1'b0;
    nop();
    @(negedge clk);
    #1;
    check("reset_ctl", 32'(ctl), 32'(CFlush));
    check("reset_exc", 32'(exc_stat), 32'd0);
    rst_n = 1'b1;
    flushPhase("flush1");

    nop();                                                          step("run_nop", CIdle);
    setIn(4'h1, 4'h5, 4'h1, 4'h3, 4'h3, 4'hF, 1'b1, 2'd0, 2'd0);    step("loaduse_a", CLoad);
    nop();                                                          step("after_lu", CIdle);
    setIn(4'h1, 4'h5, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0);    step("rnone_nolu", CIdle);
    setIn(4'h1, 4'hB, 4'h1, 4'h4, 4'h1, 4'h4, 1'b1, 2'd0, 2'd0);    step("loaduse_popb", CLoad);
    setIn(4'h9, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0);    step("ret_d", CRet);
    setIn(4'h1, 4'h9, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0);    step("ret_e", CRet);
    setIn(4'h1, 4'h1, 4'h9, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0);    step("ret_m", CRet);
    nop();                                                          step("ret_done", CIdle);
    setIn(4'h9, 4'h5, 4'h1, 4'h2, 4'h2, 4'hF, 1'b1, 2'd0, 2'd0);    step("ret_plus_lu", CLoad);
    setIn(4'h9, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 2'd0, 2'd0);    step("ret_mispred", 8'b1011_0000);
    setIn(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 2'd0, 2'd0);    step("mispred", 8'b0011_0000);
    setIn(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0);    step("jxx_taken", CIdle);
    setIn(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0);    step("opq_setcc", 8'b0000_0010);
    setIn(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd2, 2'd0);    step("mbad_run", 8'b0000_1000);
    setIn(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0);    step("drain_wok", 8'b1101_1000);
    setIn(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd2);    step("drain_wbad", 8'b1101_1100);
    nop();
    #1;
    check("halted_ctl", 32'(ctl), 32'(8'b1101_1101));
    check("halted_exc", 32'(exc_stat), 32'd2);
    @(negedge clk);
    setIn(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd1);
    @(negedge clk);
    #1;
    check("halted_hold", 32'(ctl), 32'(8'b1101_1101));
    check("exc_hold", 32'(exc_stat), 32'd2);

    #1 rst_n = 1'b0;
    #1;
    check("async_rst_ctl", 32'(ctl), 32'(CFlush));
    check("async_rst_exc", 32'(exc_stat), 32'd0);
    nop();
    @(negedge clk);
    rst_n = 1'b1;
    flushPhase("flush2");

    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 6) begin
        setIn(4'h1, 4'h5, 4'h1, 4'h3, 4'h3, 4'hF, 1'b1, 2'd0, 2'd0);
        step("perf_lu", CLoad);
      end else begin
        nop();
        step("perf_nop", CIdle);
      end
    end
`ifdef PIPE_CTRL_PERF_EN
    check("cyc_cnt", cyc_cnt, 32'd10);
    check("lu_cnt", lu_cnt, 32'd2);
    check("ret_cnt", ret_cnt, 32'd0);
    check("mp_cnt", mp_cnt, 32'd0);
`endif

    setIn(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd3, 2'd3);    step("both_bad_run", 8'b0000_1100);
    #1;
    check("direct_halt", 32'(ctl), 32'(8'b1101_1101));
    check("direct_exc", 32'(exc_stat), 32'd3);
    @(negedge clk);
    #1;
    check("still_halted", 32'(halted), 32'd1);
`ifdef PIPE_CTRL_PERF_EN
    check("cyc_freeze", cyc_cnt, 32'd11);
    check("lu_freeze", lu_cnt, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
